// File: rtl/io_chk_pkg.sv
// Shared types for the IO expectation checker.
// Holds the run-state encoding and default channel geometry.
package io_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_e;

  localparam int unsigned DEF_NUM_CH = 11;
  localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/io_chk_table.sv
// Expected-event table: one write port, one async read port.
// Each entry packs {channel, data}.
module io_chk_table #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CH_W   = 4,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [CH_W-1:0]   wch_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [CH_W-1:0]   rch_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [CH_W+DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= {wch_i, wdata_i};
  end

  assign {rch_o, rdata_o} = mem_q[raddr_i];

endmodule

// File: rtl/io_expect_checker.sv
// Watches IO channels for an ordered list of expected changes.
// Reports pass, mismatch, strict violation or timeout.
module io_expect_checker
  import io_chk_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned STRICT = 0,
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned IW   = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [NUM_CH*DATA_W-1:0] io_bus_i,
  input  logic                     exp_we_i,
  input  logic [AW-1:0]            exp_waddr_i,
  input  logic [CH_W-1:0]          exp_ch_i,
  input  logic [DATA_W-1:0]        exp_data_i,
  input  logic [IW-1:0]            exp_count_i,
  input  logic [CNT_W-1:0]         max_cycles_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [IW-1:0]            match_idx_o,
  output logic [CH_W-1:0]          err_ch_o,
  output logic [DATA_W-1:0]        err_data_o,
  output logic [CNT_W-1:0]         cycle_cnt_o
);

  state_e                   state_q, state_d;
  logic [NUM_CH*DATA_W-1:0] snap_q, snap_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [IW-1:0]            lim_q, lim_d;
  logic [CNT_W-1:0]         cyc_q, cyc_d;
  logic [CNT_W-1:0]         max_q, max_d;
  logic                     tmo_q, tmo_d;
  logic [CH_W-1:0]          ech_q, ech_d;
  logic [DATA_W-1:0]        edat_q, edat_d;

  logic              idle_like;
  logic              left;
  logic              tmo_hit;
  logic [CNT_W-1:0]  cyc_inc;
  logic [CH_W-1:0]   tch;
  logic [DATA_W-1:0] tdat;
  logic              hit;
  logic              bad;
  logic [CH_W-1:0]   bad_ch;
  logic [DATA_W-1:0] bad_dat;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_PASS) ||
                     (state_q == ST_FAIL);
  assign left      = idx_q < lim_q;
  assign cyc_inc   = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
  assign tmo_hit   = cyc_inc >= max_q;

  io_chk_table #(
    .DEPTH  (DEPTH),
    .CH_W   (CH_W),
    .DATA_W (DATA_W)
  ) u_table (
    .clk_i   (clk_i),
    .we_i    (exp_we_i & idle_like),
    .waddr_i (exp_waddr_i),
    .wch_i   (exp_ch_i),
    .wdata_i (exp_data_i),
    .raddr_i (idx_q[AW-1:0]),
    .rch_o   (tch),
    .rdata_o (tdat)
  );

  // Descending scan so the lowest offending channel wins.
  always_comb begin
    hit     = 1'b0;
    bad     = 1'b0;
    bad_ch  = '0;
    bad_dat = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (io_bus_i[c*DATA_W +: DATA_W] != snap_q[c*DATA_W +: DATA_W]) begin
        if (CH_W'(c) == tch && io_bus_i[c*DATA_W +: DATA_W] == tdat) begin
          hit = 1'b1;
        end else if (CH_W'(c) == tch || STRICT != 0) begin
          bad     = 1'b1;
          bad_ch  = CH_W'(c);
          bad_dat = io_bus_i[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start_i) state_d = ST_ARM;
      end
      ST_ARM: state_d = (lim_q == '0) ? ST_PASS : ST_RUN;
      ST_RUN: begin
        if (!left)                state_d = ST_PASS;
        else if (bad)             state_d = ST_FAIL;
        else if (!hit && tmo_hit) state_d = ST_FAIL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == ST_ARM) || (state_q == ST_RUN);
    pass_o = state_q == ST_PASS;
    fail_o = state_q == ST_FAIL;
    done_o = pass_o | fail_o;
  end

  always_comb begin
    snap_d = snap_q;
    idx_d  = idx_q;
    lim_d  = lim_q;
    cyc_d  = cyc_q;
    max_d  = max_q;
    tmo_d  = tmo_q;
    ech_d  = ech_q;
    edat_d = edat_q;
    if (idle_like && start_i) begin
      lim_d = exp_count_i;
      max_d = max_cycles_i;
    end
    if (state_q == ST_ARM) begin
      snap_d = io_bus_i;
      idx_d  = '0;
      cyc_d  = '0;
      tmo_d  = 1'b0;
      ech_d  = '0;
      edat_d = '0;
    end
    if (state_q == ST_RUN) begin
      snap_d = io_bus_i;
      cyc_d  = cyc_inc;
      if (left) begin
        if (bad) begin
          ech_d  = bad_ch;
          edat_d = bad_dat;
        end else if (hit) begin
          idx_d = idx_q + 1'b1;
        end else if (tmo_hit) begin
          tmo_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_q <= '0;
      idx_q  <= '0;
      lim_q  <= '0;
      cyc_q  <= '0;
      max_q  <= '0;
      tmo_q  <= 1'b0;
      ech_q  <= '0;
      edat_q <= '0;
    end else begin
      snap_q <= snap_d;
      idx_q  <= idx_d;
      lim_q  <= lim_d;
      cyc_q  <= cyc_d;
      max_q  <= max_d;
      tmo_q  <= tmo_d;
      ech_q  <= ech_d;
      edat_q <= edat_d;
    end
  end

  assign timeout_o   = tmo_q;
  assign match_idx_o = idx_q;
  assign err_ch_o    = ech_q;
  assign err_data_o  = edat_q;
  assign cycle_cnt_o = cyc_q;

endmodule

// File: tb/tb_io_expect_checker.sv
// Bench for io_expect_checker: STRICT=0 and STRICT=1 instances
// checked every cycle against a behavioural model.
module tb_io_expect_checker;

  localparam int NC  = 11;
  localparam int DW  = 32;
  localparam int DP  = 16;
  localparam int CW  = 16;
  localparam int CHW = $clog2(NC);
  localparam int AW  = $clog2(DP);
  localparam int IW  = $clog2(DP + 1);

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_RUN  = 2;
  localparam int P_PASS = 3;
  localparam int P_FAIL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic we = 1'b0;
  logic [NC*DW-1:0] bus = '0;
  logic [AW-1:0] waddr = '0;
  logic [CHW-1:0] wch = '0;
  logic [DW-1:0] wdata = '0;
  logic [IW-1:0] ecount = '0;
  logic [CW-1:0] maxc = '0;

  logic [1:0] busy, done, pass, fail, tmo;
  logic [IW-1:0] midx [2];
  logic [CHW-1:0] ech [2];
  logic [DW-1:0] edat [2];
  logic [CW-1:0] cyc [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    io_expect_checker #(
      .NUM_CH (NC),
      .DATA_W (DW),
      .DEPTH  (DP),
      .CNT_W  (CW),
      .STRICT (k)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .io_bus_i     (bus),
      .exp_we_i     (we),
      .exp_waddr_i  (waddr),
      .exp_ch_i     (wch),
      .exp_data_i   (wdata),
      .exp_count_i  (ecount),
      .max_cycles_i (maxc),
      .busy_o       (busy[k]),
      .done_o       (done[k]),
      .pass_o       (pass[k]),
      .fail_o       (fail[k]),
      .timeout_o    (tmo[k]),
      .match_idx_o  (midx[k]),
      .err_ch_o     (ech[k]),
      .err_data_o   (edat[k]),
      .cycle_cnt_o  (cyc[k])
    );
  end

  // Behavioural model, one copy per instance (index = STRICT).
  int m_ph [2];
  int m_tc [2][DP];
  logic [DW-1:0] m_td [2][DP];
  int m_n [2];
  int m_max [2];
  int m_idx [2];
  int m_cyc [2];
  int m_ech [2];
  logic [DW-1:0] m_edat [2];
  bit m_to [2];
  logic [NC*DW-1:0] m_prev [2];

  function automatic void chk(string nm, int k,
                              logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h", nm, k, act, exp);
    end
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = P_IDLE;
      m_n[k] = 0;
      m_max[k] = 0;
      m_idx[k] = 0;
      m_cyc[k] = 0;
      m_ech[k] = 0;
      m_edat[k] = '0;
      m_to[k] = 1'b0;
      m_prev[k] = '0;
    end
  endfunction

  function automatic bit m_busy(int k);
    return m_ph[k] == P_ARM || m_ph[k] == P_RUN;
  endfunction

  function automatic void m_step();
    int bad;
    bit hit;
    logic [DW-1:0] v;
    for (int k = 0; k < 2; k++) begin
      case (m_ph[k])
        P_ARM: begin
          m_prev[k] = bus;
          m_idx[k] = 0;
          m_cyc[k] = 0;
          m_ech[k] = 0;
          m_edat[k] = '0;
          m_to[k] = 1'b0;
          m_ph[k] = (m_n[k] == 0) ? P_PASS : P_RUN;
        end
        P_RUN: begin
          if (m_cyc[k] < 65535) m_cyc[k]++;
          if (m_idx[k] == m_n[k]) begin
            m_ph[k] = P_PASS;
          end else begin
            bad = -1;
            hit = 1'b0;
            for (int c = 0; c < NC; c++) begin
              v = bus[c*DW +: DW];
              if (v != m_prev[k][c*DW +: DW]) begin
                if (c == m_tc[k][m_idx[k]]) begin
                  if (v == m_td[k][m_idx[k]]) hit = 1'b1;
                  else if (bad < 0) bad = c;
                end else if (k == 1 && bad < 0) begin
                  bad = c;
                end
              end
            end
            if (bad >= 0) begin
              m_ph[k] = P_FAIL;
              m_ech[k] = bad;
              m_edat[k] = bus[bad*DW +: DW];
            end else if (hit) begin
              m_idx[k]++;
            end else if (m_cyc[k] >= m_max[k]) begin
              m_ph[k] = P_FAIL;
              m_to[k] = 1'b1;
            end
          end
          m_prev[k] = bus;
        end
        default: begin
          if (we) begin
            m_tc[k][waddr] = int'(wch);
            m_td[k][waddr] = wdata;
          end
          if (start) begin
            m_n[k] = int'(ecount);
            m_max[k] = int'(maxc);
            m_ph[k] = P_ARM;
          end
        end
      endcase
    end
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("busy", k, busy[k], m_busy(k));
      chk("done", k, done[k], m_ph[k] == P_PASS || m_ph[k] == P_FAIL);
      chk("pass", k, pass[k], m_ph[k] == P_PASS);
      chk("fail", k, fail[k], m_ph[k] == P_FAIL);
      chk("timeout", k, tmo[k], m_to[k]);
      chk("match_idx", k, midx[k], m_idx[k]);
      chk("err_ch", k, ech[k], m_ech[k]);
      chk("err_data", k, edat[k], m_edat[k]);
      chk("cycle_cnt", k, cyc[k], m_cyc[k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(int a, int ch, logic [DW-1:0] d);
    we = 1'b1;
    waddr = AW'(a);
    wch = CHW'(ch);
    wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic set_ch(int c, logic [DW-1:0] v);
    bus[c*DW +: DW] = v;
  endtask

  task automatic go(int n, int mx);
    ecount = IW'(n);
    maxc = CW'(mx);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int bound;
    int r;
    m_reset();
    repeat (3) tick();
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_done", 0, done[0], 0);
    chk("rst_cyc", 0, cyc[0], 0);
    rst_n = 1'b1;
    tick();

    // Two-entry ordered match
    wr(0, 0, 32'h1357_9BDF);
    wr(1, 3, 32'h40);
    go(2, 100);
    tick();
    set_ch(0, 32'h1357_9BDF);
    tick();
    tick();
    set_ch(3, 32'h40);
    repeat (3) tick();
    chk("seq_pass", 0, pass[0], 1);
    chk("seq_idx", 0, midx[0], 2);
    chk("seq_pass_strict", 1, pass[1], 1);

    // Wrong value on expected channel
    wr(0, 1, 32'h5);
    go(1, 100);
    tick();
    set_ch(1, 32'h6);
    tick();
    chk("mis_fail", 0, fail[0], 1);
    chk("mis_ch", 0, ech[0], 1);
    chk("mis_data", 0, edat[0], 6);
    chk("mis_tmo", 0, tmo[0], 0);

    // Timeout with a quiet bus
    go(1, 10);
    tick();
    repeat (12) tick();
    chk("to_fail", 0, fail[0], 1);
    chk("to_flag", 0, tmo[0], 1);
    chk("to_cnt", 0, cyc[0], 10);

    // Simultaneous non-expected change
    wr(0, 0, 32'h11);
    wr(1, 5, 32'h22);
    go(2, 100);
    tick();
    set_ch(0, 32'h11);
    set_ch(2, 32'h99);
    tick();
    chk("strict_fail", 1, fail[1], 1);
    chk("strict_ch", 1, ech[1], 2);
    chk("lax_idx", 0, midx[0], 1);
    set_ch(5, 32'h22);
    repeat (3) tick();
    chk("lax_pass", 0, pass[0], 1);

    // Empty table passes right after ARM
    go(0, 100);
    chk("empty_arm", 0, busy[0], 1);
    tick();
    chk("empty_pass", 0, pass[0], 1);

    // Reset during a run
    go(1, 1000);
    tick();
    tick();
    chk("pre_rst_busy", 0, busy[0], 1);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("abort_busy", 0, busy[0], 0);
    chk("abort_pass", 0, pass[0], 0);
    chk("abort_fail", 0, fail[0], 0);
    chk("abort_cyc", 0, cyc[0], 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized runs
    for (int a = 0; a < DP; a++) wr(a, $urandom_range(0, NC - 1), $urandom());
    repeat (40) begin
      if ($urandom_range(0, 3) == 0)
        wr($urandom_range(0, DP - 1), $urandom_range(0, NC - 1), $urandom());
      go($urandom_range(0, 6), $urandom_range(4, 60));
      bound = 0;
      while ((m_busy(0) || m_busy(1)) && bound < 200) begin
        r = $urandom_range(0, 99);
        if (r < 45 && m_ph[0] == P_RUN && m_idx[0] < m_n[0])
          set_ch(m_tc[0][m_idx[0]], m_td[0][m_idx[0]]);
        else if (r < 58)
          set_ch($urandom_range(0, NC - 1), $urandom());
        if (m_ph[0] == P_RUN && m_ph[1] == P_RUN &&
            $urandom_range(0, 9) == 0) begin
          start = 1'b1;
          we = 1'b1;
          waddr = AW'($urandom_range(0, DP - 1));
          wch = CHW'($urandom_range(0, NC - 1));
          wdata = $urandom();
        end
        tick();
        start = 1'b0;
        we = 1'b0;
        bound++;
      end
      chk("run_bound", 0, bound < 200, 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_expect_checker.md
IO_EXPECT_CHECKER -- requirements
Module: io_expect_checker

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 11, number of watched IO channels; DATA_W, default 32, channel width; DEPTH, default 16, expected-event table entries; CNT_W, default 16, cycle counter width; STRICT, default 0, 1 = unexpected channel changes fail.
REQ-002 Ports, one per line (name direction width meaning): clk_i in 1 clock; rst_ni in 1 reset. Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 start_i in 1 begin a check run (pulse).
REQ-004 io_bus_i in NUM_CH*DATA_W concatenated channels, channel c at bits [c*DATA_W +: DATA_W].
REQ-005 exp_we_i in 1; exp_waddr_i in clog2(DEPTH); exp_ch_i in clog2(NUM_CH); exp_data_i in DATA_W: table write port.
REQ-006 exp_count_i in clog2(DEPTH+1) number of valid entries; max_cycles_i in CNT_W run timeout.
REQ-007 busy_o, done_o, pass_o, fail_o, timeout_o out 1 status; match_idx_o out clog2(DEPTH+1) entries matched; err_ch_o out clog2(NUM_CH); err_data_o out DATA_W; cycle_cnt_o out CNT_W.

Function
REQ-008 States SHALL be IDLE, ARM, RUN, PASS, FAIL.
REQ-009 IDLE: table writes accepted (entry written at clock edge with exp_we_i=1); start_i=1 -> ARM; exp_count_i and max_cycles_i latched at that edge.
REQ-010 ARM (exactly one cycle): io_bus_i captured into prev snapshot; match index and cycle counter cleared to 0; -> RUN, or -> PASS if latched count = 0.
REQ-011 RUN: per edge, change vector = io_bus_i XOR snapshot per channel; snapshot updated to io_bus_i every RUN edge.
REQ-012 Change on expected channel exp_ch[idx] with value = exp_data[idx]: idx increments by exactly 1; at most one entry consumed per cycle.
REQ-013 Change on expected channel with any other value: -> FAIL, err_ch_o/err_data_o = that channel/value.
REQ-014 STRICT=1: change on any non-expected channel in the same or any RUN cycle -> FAIL with lowest-index offending channel reported, even if expected channel matched same cycle; STRICT=0: such changes ignored.
REQ-015 idx reaching latched count -> PASS on the following edge; done_o, pass_o asserted from that cycle.
REQ-016 cycle_cnt_o increments each RUN cycle, saturates at all-ones; reaching latched max_cycles_i with idx < count -> FAIL with timeout_o=1; match on the same edge takes priority over timeout.
REQ-017 PASS/FAIL hold status until start_i=1, which -> ARM (re-run with current table).
REQ-018 start_i and exp_we_i SHALL be ignored in ARM and RUN; busy_o=1 exactly in ARM and RUN.
REQ-019 match_idx_o, cycle_cnt_o SHALL reflect live registers; err_ch_o/err_data_o hold last failure until next ARM.

Reset
REQ-020 rst_ni low: state IDLE, all outputs 0, snapshot and counters 0; table contents need not reset.
REQ-021 Reset asserted mid-RUN SHALL abort immediately with no PASS/FAIL indication.

Structure
REQ-022 Shared package io_chk_pkg SHALL hold the state enum and the default channel count/width constants used by pipeline IO mapping.
REQ-023 Expected table SHALL be one sub-module io_chk_table (DEPTH x (clog2(NUM_CH)+DATA_W) register array, one write port, one async read port).

Verification
REQ-024 Table {(ch0,0x13579BDF),(ch3,0x40)}, count 2, channel 0 then channel 3 driven to those values on separate cycles -> pass_o=1, match_idx_o=2.
REQ-025 Entry 0 (ch1,0x5), ch1 driven to 0x6 -> fail_o=1, err_ch_o=1, err_data_o=0x6, timeout_o=0.
REQ-026 max_cycles 10, no channel changes -> fail_o=1, timeout_o=1, cycle_cnt_o=10.
REQ-027 STRICT=1, ch2 changes simultaneously with correct ch0 match -> fail_o=1, err_ch_o=2; same stimulus STRICT=0 -> match_idx_o advances.
REQ-028 count 0 with start -> pass_o one cycle after ARM; rst_ni pulsed low during RUN -> all status 0, state IDLE.
